// File: rtl/timer_scheduler.sv
// rtl/timer_scheduler.sv - round-robin sharing of one down-counting timer among CHANNELS requesters
// All outputs are registered from the next state so the timer sees enable low only while WAIT is held.
module timer_scheduler #(
  parameter int CHANNELS = 4,
  parameter int BITS     = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [CHANNELS-1:0]      req,
  input  logic [CHANNELS*BITS-1:0] timeout,
  output logic [CHANNELS-1:0]      grant,
  output logic [CHANNELS-1:0]      done,
  output logic                     busy,
  output logic [BITS-1:0]          tmr_timeout,
  output logic                     tmr_enable,
  input  logic                     tmr_flag
);
  localparam int IW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [IW:0]   CH_W = (IW+1)'(CHANNELS);
  localparam logic [IW-1:0] LAST = IW'(CHANNELS - 1);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, DONE} state_t;

  state_t                state, state_n;
  logic [IW-1:0]         owner, owner_n, rr, rr_n, pick, owner_inc;
  logic                  found;
  logic [BITS-1:0]       tmo_n;
  logic [CHANNELS-1:0]   owner_oh;

  // First requester at or after the rr pointer, wrapping past the last channel.
  always_comb begin : pick_logic
    logic [IW:0] sum;
    found = 1'b0;
    pick  = rr;
    sum   = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      sum = {1'b0, rr} + (IW+1)'(k);
      if (sum >= CH_W) sum = sum - CH_W;
      if (!found && req[sum[IW-1:0]]) begin
        found = 1'b1;
        pick  = sum[IW-1:0];
      end
    end
  end

  assign owner_inc = (owner == LAST) ? '0 : owner + 1'b1;

  always_comb begin
    state_n = state;
    owner_n = owner;
    rr_n    = rr;
    tmo_n   = tmr_timeout;
    case (state)
      IDLE: begin
        if (found) begin
          state_n = LOAD;
          owner_n = pick;
          tmo_n   = timeout[pick*BITS +: BITS];
        end
      end
      LOAD: begin
        if (!req[owner]) begin
          state_n = IDLE;
          rr_n    = owner_inc;
        end else begin
          state_n = WAIT;
        end
      end
      WAIT: begin
        if (!req[owner]) begin
          state_n = IDLE;
          rr_n    = owner_inc;
        end else if (tmr_flag) begin
          state_n = DONE;
        end
      end
      DONE: begin
        state_n = IDLE;
        rr_n    = owner_inc;
      end
      default: state_n = IDLE;
    endcase
  end

  assign owner_oh = CHANNELS'(1) << owner_n;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      owner       <= '0;
      rr          <= '0;
      grant       <= '0;
      done        <= '0;
      busy        <= 1'b0;
      tmr_timeout <= '0;
      tmr_enable  <= 1'b1;
    end else begin
      state       <= state_n;
      owner       <= owner_n;
      rr          <= rr_n;
      tmr_timeout <= tmo_n;
      grant       <= (state_n != IDLE) ? owner_oh : '0;
      done        <= (state_n == DONE) ? owner_oh : '0;
      busy        <= (state_n != IDLE);
      tmr_enable  <= (state_n != WAIT);
    end
  end
endmodule

// File: tb/tb_timer_scheduler.sv
// tb/tb_timer_scheduler.sv - self-checking bench for timer_scheduler with a shared-timer model
// Expected outputs come from a grant-relative cycle-count model of the scheduler.
module tb_timer_scheduler;
  localparam int CH   = 4;
  localparam int BITS = 8;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [CH-1:0]     req = '0;
  logic [CH*BITS-1:0] timeout = '0;
  logic [CH-1:0]     grant, done;
  logic              busy, tmr_enable, tmr_flag;
  logic [BITS-1:0]   tmr_timeout;

  int checks = 0;
  int failures = 0;
  int done_pulses = 0;

  timer_scheduler #(.CHANNELS(CH), .BITS(BITS)) dut (
    .clock(clock), .reset(reset), .req(req), .timeout(timeout),
    .grant(grant), .done(done), .busy(busy),
    .tmr_timeout(tmr_timeout), .tmr_enable(tmr_enable), .tmr_flag(tmr_flag)
  );

  always #5 clock = ~clock;

  // Shared down-counting timer: enable loads and clears the flag, otherwise counts to zero and flags.
  logic [BITS-1:0] t_count = '0;
  logic            t_flag  = 1'b0;
  assign tmr_flag = t_flag;
  always @(posedge clock) begin
    if (tmr_enable) begin
      t_count <= tmr_timeout;
      t_flag  <= 1'b0;
    end else if (t_count == 0) begin
      t_flag  <= 1'b1;
    end else begin
      t_count <= t_count - 1'b1;
    end
  end

  // Reference: one owner at a time, grant from cycle start through start+T+3, done at start+T+3.
  bit              m_active = 0;
  int              m_owner = 0;
  int              m_rr = 0;
  longint          m_T = 0;
  longint          m_start = 0;
  longint          cyc = 0;
  logic [BITS-1:0] m_tmo = '0;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_active = 0;
      m_rr     = 0;
      m_tmo    = '0;
    end else begin
      if (m_active) begin
        if ((cyc - m_start) == m_T + 3 || !req[m_owner]) begin
          m_active = 0;
          m_rr     = (m_owner + 1) % CH;
        end
      end else if (req != 0) begin
        for (int j = 0; j < CH; j++) begin
          if (req[(m_rr + j) % CH]) begin
            m_owner = (m_rr + j) % CH;
            break;
          end
        end
        m_active = 1;
        m_tmo    = timeout[m_owner*BITS +: BITS];
        m_T      = longint'(m_tmo);
        m_start  = cyc + 1;
      end
      cyc = cyc + 1;
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clock) begin
    longint k;
    logic [CH-1:0] oh;
    if (|done) done_pulses++;
    if (!reset) begin
      k  = cyc - m_start;
      oh = m_active ? CH'(1) << m_owner : '0;
      chk("cyc_grant", longint'(grant), longint'(oh));
      chk("cyc_done", longint'(done), (m_active && k == m_T + 3) ? longint'(oh) : 0);
      chk("cyc_busy", longint'(busy), longint'(m_active));
      chk("cyc_enable", longint'(tmr_enable), (m_active && k >= 1 && k <= m_T + 2) ? 0 : 1);
      chk("cyc_tmr_timeout", longint'(tmr_timeout), longint'(m_tmo));
    end
  end

  // mode 0: grant==want, 1: done==want, 2: grant nonzero
  task automatic wait_cond(input int mode, input logic [CH-1:0] want, input int budget,
                           input string name, output longint at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if ((mode == 0 && grant == want) || (mode == 1 && done == want) ||
          (mode == 2 && grant != 0)) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      checks++;
      failures++;
      $display("FAIL %s: timed out after %0d cycles", name, budget);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    req   = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    longint c, d, x;
    int p0;
    logic [CH-1:0] g;

    // 1: single request, T=5
    do_reset();
    chk("reset_grant", longint'(grant), 0);
    chk("reset_enable", longint'(tmr_enable), 1);
    chk("reset_tmr_timeout", longint'(tmr_timeout), 0);
    timeout[2*BITS +: BITS] = 8'd5;
    req = 4'b0100;
    wait_cond(0, 4'b0100, 20, "t1_grant", c);
    wait_cond(1, 4'b0100, 20, "t1_done", d);
    chk("t1_done_latency", d - c, 8);
    req = '0;
    @(negedge clock);
    chk("t1_grant_clear", longint'(grant), 0);
    chk("t1_clear_cycle", cyc - c, 9);

    // 2: all requesting, T=0, round-robin order
    do_reset();
    timeout = '0;
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_cond(2, '0, 30, "t2_grant", c);
      g = grant;
      chk("t2_order", longint'(g), longint'(CH'(1) << (i % CH)));
      wait_cond(1, g, 10, "t2_done", d);
      chk("t2_latency", d - c, 3);
      wait_cond(0, '0, 5, "t2_release", x);
    end
    req = '0;

    // 3: cancel in WAIT
    do_reset();
    timeout[1*BITS +: BITS] = 8'd100;
    req = 4'b0010;
    wait_cond(0, 4'b0010, 20, "t3_grant", c);
    p0 = done_pulses;
    repeat (20) @(negedge clock);
    req = '0;
    @(negedge clock);
    chk("t3_cancel_grant", longint'(grant), 0);
    chk("t3_cancel_cycle", cyc - c, 21);
    repeat (120) @(negedge clock);
    chk("t3_no_done", longint'(done_pulses - p0), 0);

    // 4: timeout change after grant is ignored
    do_reset();
    timeout[0 +: BITS] = 8'd10;
    req = 4'b0001;
    wait_cond(0, 4'b0001, 20, "t4_grant", c);
    @(negedge clock);
    timeout[0 +: BITS] = 8'd3;
    wait_cond(1, 4'b0001, 30, "t4_done", d);
    chk("t4_latched_latency", d - c, 13);
    req = '0;

    // 5: reset during WAIT
    do_reset();
    timeout[3*BITS +: BITS] = 8'd50;
    req = 4'b1000;
    wait_cond(0, 4'b1000, 20, "t5_grant", c);
    repeat (10) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    chk("t5_busy", longint'(busy), 0);
    chk("t5_grant", longint'(grant), 0);
    chk("t5_done", longint'(done), 0);
    chk("t5_enable", longint'(tmr_enable), 1);
    @(negedge clock);
    reset = 1'b0;
    wait_cond(2, '0, 20, "t5_regrant", c);
    chk("t5_first_grant", longint'(grant), 4'b1000);
    req = '0;
    wait_cond(0, '0, 70, "t5_release", x);

    // 6: boundary timeouts
    do_reset();
    timeout[0 +: BITS] = 8'd0;
    req = 4'b0001;
    wait_cond(0, 4'b0001, 20, "t6a_grant", c);
    wait_cond(1, 4'b0001, 10, "t6a_done", d);
    chk("t6_t0_latency", d - c, 3);
    req = '0;
    wait_cond(0, '0, 5, "t6a_release", x);
    timeout[0 +: BITS] = 8'd255;
    req = 4'b0001;
    wait_cond(0, 4'b0001, 20, "t6b_grant", c);
    wait_cond(1, 4'b0001, 300, "t6b_done", d);
    chk("t6_tmax_latency", d - c, 258);
    req = '0;
    wait_cond(0, '0, 5, "t6b_release", x);

    // Random traffic checked cycle by cycle against the model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      @(negedge clock);
      for (int ch = 0; ch < CH; ch++) begin
        if ($urandom_range(7) == 0) req[ch] = ~req[ch];
        if ($urandom_range(3) == 0) timeout[ch*BITS +: BITS] = BITS'($urandom_range(12));
      end
      if ($urandom_range(499) == 0) begin
        #2 reset = 1'b1;
        @(negedge clock);
        #2 reset = 1'b0;
      end
    end
    req = '0;
    repeat (20) @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
